// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: PC generation, BTB-based next-PC prediction,
// 1-cycle synchronous ROM access and a small fetch queue towards decode.
module ifetch_queue #(
   parameter int unsigned          ADDR_W   = 32,
   parameter int unsigned          ROM_AW   = 14,
   parameter int unsigned          QDEPTH   = 4,
   parameter int unsigned          BTB_IDX  = 4,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_rst,
   output logic [ROM_AW-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_pc,
   output logic [ADDR_W-1:0] out_pred_next,
   output logic              out_pred_taken,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target
);

   localparam int unsigned QAW   = $clog2(QDEPTH);
   localparam int unsigned CW    = QAW + 1;
   localparam int unsigned BTB_N = 1 << BTB_IDX;
   localparam int unsigned TAG_W = ADDR_W - BTB_IDX - 2;

   // PC and the single outstanding ROM access
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              infl_q, infl_d;
   logic [ADDR_W-1:0] infl_pc_q, infl_pred_q;
   logic              infl_tk_q;

   // fetch queue storage and pointers
   logic [QDEPTH-1:0][31:0]       q_inst_q;
   logic [QDEPTH-1:0][ADDR_W-1:0] q_pc_q, q_pred_q;
   logic [QDEPTH-1:0]             q_tk_q;
   logic [QAW-1:0]                head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]                 cnt_q, cnt_d;

   // last visible head, shown while the queue is empty
   logic [31:0]       hold_inst_q;
   logic [ADDR_W-1:0] hold_pc_q, hold_pred_q;
   logic              hold_tk_q;

   // branch target buffer
   logic [BTB_N-1:0]              btb_vld_q;
   logic [BTB_N-1:0][TAG_W-1:0]   btb_tag_q;
   logic [BTB_N-1:0][ADDR_W-1:0]  btb_tgt_q;
   logic [BTB_N-1:0][1:0]         btb_ctr_q;

   logic [BTB_IDX-1:0] lk_idx, u_idx;
   logic [TAG_W-1:0]   lk_tag, u_tag;
   logic               lk_hit, u_hit;
   logic [ADDR_W-1:0]  pred_pc;
   logic [CW-1:0]      occ;
   logic               flush, issue, push, pop;
   logic               unused_bits;

   assign unused_bits = ^{redirect_pc[1:0], upd_pc[1:0]};

   // prediction for the PC being issued; lookup sees the BTB before this cycle's update
   assign lk_idx  = pc_q[BTB_IDX+1:2];
   assign lk_tag  = pc_q[ADDR_W-1:BTB_IDX+2];
   assign lk_hit  = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) && btb_ctr_q[lk_idx][1];
   assign pred_pc = lk_hit ? btb_tgt_q[lk_idx] : pc_q + ADDR_W'(4);

   assign u_idx = upd_pc[BTB_IDX+1:2];
   assign u_tag = upd_pc[ADDR_W-1:BTB_IDX+2];
   assign u_hit = btb_vld_q[u_idx] && (btb_tag_q[u_idx] == u_tag);

   // issue only when the returning word is guaranteed a queue slot
   assign flush = soft_rst || redirect_valid;
   assign occ   = cnt_q + CW'(infl_q);
   assign issue = !flush && (occ < CW'(QDEPTH));
   assign push  = infl_q && !flush;
   assign pop   = (cnt_q != '0) && out_ready && !flush;

   assign imem_addr      = pc_q[ROM_AW+1:2];
   assign out_valid      = (cnt_q != '0);
   assign out_inst       = out_valid ? q_inst_q[head_q] : hold_inst_q;
   assign out_pc         = out_valid ? q_pc_q[head_q]   : hold_pc_q;
   assign out_pred_next  = out_valid ? q_pred_q[head_q] : hold_pred_q;
   assign out_pred_taken = out_valid ? q_tk_q[head_q]   : hold_tk_q;

   // next PC, in-flight flag and queue pointers
   always_comb begin
      pc_d   = pc_q;
      infl_d = issue;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (soft_rst) begin
         pc_d   = RESET_PC;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else if (redirect_valid) begin
         pc_d   = {redirect_pc[ADDR_W-1:2], 2'b00};
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (issue) pc_d = pred_pc;
         if (push)  tail_d = tail_q + QAW'(1);
         if (pop)   head_d = head_q + QAW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   // PC and in-flight tracking registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         infl_q      <= 1'b0;
         infl_pc_q   <= '0;
         infl_pred_q <= '0;
         infl_tk_q   <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         infl_q <= infl_d;
         if (issue) begin
            infl_pc_q   <= pc_q;
            infl_pred_q <= pred_pc;
            infl_tk_q   <= lk_hit;
         end
      end
   end

   // queue storage, pointers and the empty-queue hold registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_inst_q    <= '0;
         q_pc_q      <= '0;
         q_pred_q    <= '0;
         q_tk_q      <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         hold_inst_q <= '0;
         hold_pc_q   <= '0;
         hold_pred_q <= '0;
         hold_tk_q   <= 1'b0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         if (soft_rst) begin
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
            hold_pred_q <= '0;
            hold_tk_q   <= 1'b0;
         end else if (out_valid) begin
            hold_inst_q <= q_inst_q[head_q];
            hold_pc_q   <= q_pc_q[head_q];
            hold_pred_q <= q_pred_q[head_q];
            hold_tk_q   <= q_tk_q[head_q];
         end
         if (push) begin
            q_inst_q[tail_q] <= imem_data;
            q_pc_q[tail_q]   <= infl_pc_q;
            q_pred_q[tail_q] <= infl_pred_q;
            q_tk_q[tail_q]   <= infl_tk_q;
         end
      end
   end

   // BTB training from execute; survives soft restart
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btb_vld_q <= '0;
         btb_tag_q <= '0;
         btb_tgt_q <= '0;
         btb_ctr_q <= '0;
      end else if (upd_valid) begin
         if (u_hit) begin
            if (upd_taken) begin
               if (btb_ctr_q[u_idx] != 2'd3) btb_ctr_q[u_idx] <= btb_ctr_q[u_idx] + 2'd1;
               btb_tgt_q[u_idx] <= upd_target;
            end else if (btb_ctr_q[u_idx] != 2'd0) begin
               btb_ctr_q[u_idx] <= btb_ctr_q[u_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            btb_vld_q[u_idx] <= 1'b1;
            btb_tag_q[u_idx] <= u_tag;
            btb_tgt_q[u_idx] <= upd_target;
            btb_ctr_q[u_idx] <= 2'd2;
         end
      end
   end

endmodule
